// File: rtl/execute_writeback_if.sv
// rtl/execute_writeback_if.sv - issue and writeback bus between register-allocate, execute and register file
interface execute_writeback_if #(
  parameter int DATA_W    = 8,
  parameter int REG_IDX_W = 2
);
  logic                 iVALID;
  logic                 oREADY;
  logic [2:0]           iOP;
  logic [REG_IDX_W-1:0] iDST_IDX;
  logic [DATA_W-1:0]    iSOURCE1_VAL;
  logic [DATA_W-1:0]    iSOURCE2_VAL;
  logic                 oWB_VALID;
  logic [REG_IDX_W-1:0] oNEXT_REG_IDX;
  logic [DATA_W-1:0]    oNEXT_REG_VAL;
  logic                 oBUSY;
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
  logic                 oZERO;
  logic                 oCARRY;
`endif

  // Upstream issuer / writeback consumer side
  modport master (
    output iVALID, iOP, iDST_IDX, iSOURCE1_VAL, iSOURCE2_VAL,
    input  oREADY, oWB_VALID, oNEXT_REG_IDX, oNEXT_REG_VAL, oBUSY
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
    , input oZERO, oCARRY
`endif
  );

  // Execute stage side
  modport slave (
    input  iVALID, iOP, iDST_IDX, iSOURCE1_VAL, iSOURCE2_VAL,
    output oREADY, oWB_VALID, oNEXT_REG_IDX, oNEXT_REG_VAL, oBUSY
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
    , output oZERO, oCARRY
`endif
  );
endinterface

// File: rtl/execute_writeback.sv
// rtl/execute_writeback.sv - execute/writeback stage: single-cycle ALU plus iterative MUL; optional flags via EXECUTE_WRITEBACK_FLAGS_EN
module execute_writeback #(
  parameter int DATA_W    = 8,
  parameter int REG_IDX_W = 2
) (
  input  logic               iCLK,
  input  logic               iRST,
  execute_writeback_if.slave bus
);

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
  // Keep the full product so overflow into the upper half can be flagged
  localparam int ACC_W = 2 * DATA_W;
`else
  localparam int ACC_W = DATA_W;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    mcand_q, mcand_d;
  logic [DATA_W-1:0]    mplier_q, mplier_d;
  logic [REG_IDX_W-1:0] mul_dst_q, mul_dst_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [REG_IDX_W-1:0] wb_idx_q, wb_idx_d;
  logic [DATA_W-1:0]    wb_val_q, wb_val_d;
  logic [ACC_W-1:0]     acc_step;
  logic [DATA_W-1:0]    alu_val;
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 alu_carry;
`endif

  // Single-cycle ALU result for ops 0-5
  always_comb begin
    alu_val = '0;
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
    alu_carry = 1'b0;
`endif
    case (bus.iOP)
      OP_MOV: alu_val = bus.iSOURCE2_VAL;
      OP_ADD: begin
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
        {alu_carry, alu_val} = {1'b0, bus.iSOURCE1_VAL} + {1'b0, bus.iSOURCE2_VAL};
`else
        alu_val = bus.iSOURCE1_VAL + bus.iSOURCE2_VAL;
`endif
      end
      OP_SUB: begin
        alu_val = bus.iSOURCE1_VAL - bus.iSOURCE2_VAL;
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
        alu_carry = (bus.iSOURCE1_VAL < bus.iSOURCE2_VAL);
`endif
      end
      OP_AND: alu_val = bus.iSOURCE1_VAL & bus.iSOURCE2_VAL;
      OP_OR:  alu_val = bus.iSOURCE1_VAL | bus.iSOURCE2_VAL;
      OP_XOR: alu_val = bus.iSOURCE1_VAL ^ bus.iSOURCE2_VAL;
      default: alu_val = '0;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    acc_step = acc_q + (mplier_q[cnt_q] ? (ACC_W'(mcand_q) << cnt_q) : '0);
  end

  // Next-state logic for the FSM, multiply datapath and registered writeback outputs
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    mul_dst_d  = mul_dst_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_idx_d   = wb_idx_q;
    wb_val_d   = wb_val_q;
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
    zero_d     = zero_q;
    carry_d    = carry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.iVALID) begin
          if (bus.iOP == OP_MUL) begin
            mcand_d   = bus.iSOURCE1_VAL;
            mplier_d  = bus.iSOURCE2_VAL;
            mul_dst_d = bus.iDST_IDX;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = S_MUL;
          end else if (bus.iOP != OP_NOP) begin
            wb_valid_d = 1'b1;
            wb_idx_d   = bus.iDST_IDX;
            wb_val_d   = alu_val;
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
            zero_d     = (alu_val == '0);
            carry_d    = alu_carry;
`endif
          end
        end
      end
      S_MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          wb_idx_d   = mul_dst_q;
          wb_val_d   = acc_step[DATA_W-1:0];
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
          zero_d     = (acc_step[DATA_W-1:0] == '0);
          carry_d    = |acc_step[ACC_W-1:DATA_W];
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any multiply in flight
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= S_IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      mul_dst_q  <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_val_q   <= '0;
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      mul_dst_q  <= mul_dst_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
      wb_val_q   <= wb_val_d;
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
      zero_q     <= zero_d;
      carry_q    <= carry_d;
`endif
    end
  end

  assign bus.oREADY        = (state_q == S_IDLE);
  assign bus.oBUSY         = (state_q == S_MUL);
  assign bus.oWB_VALID     = wb_valid_q;
  assign bus.oNEXT_REG_IDX = wb_idx_q;
  assign bus.oNEXT_REG_VAL = wb_val_q;
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
  assign bus.oZERO         = zero_q;
  assign bus.oCARRY        = carry_q;
`endif

endmodule

// File: tb/tb_execute_writeback.sv
// tb/tb_execute_writeback.sv - directed self-checking bench for execute_writeback
module tb_execute_writeback;

  logic iCLK;
  logic iRST;
  int   checks;
  int   failures;
  int   pulses;

  execute_writeback_if #(.DATA_W(8), .REG_IDX_W(2)) bus_if();

  execute_writeback #(.DATA_W(8), .REG_IDX_W(2)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus_if.slave)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [7:0] s1, input logic [7:0] s2);
    bus_if.iVALID       = 1'b1;
    bus_if.iOP          = op;
    bus_if.iDST_IDX     = dst;
    bus_if.iSOURCE1_VAL = s1;
    bus_if.iSOURCE2_VAL = s2;
  endtask

  task automatic check_wb(input string tag, input logic v, input logic [1:0] idx, input logic [7:0] val);
    check({tag, "_valid"}, bus_if.oWB_VALID, v);
    check({tag, "_idx"}, bus_if.oNEXT_REG_IDX, idx);
    check({tag, "_val"}, bus_if.oNEXT_REG_VAL, val);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    pulses   = 0;
    iRST     = 1'b1;
    bus_if.iVALID       = 1'b0;
    bus_if.iOP          = 3'd7;
    bus_if.iDST_IDX     = 2'd0;
    bus_if.iSOURCE1_VAL = 8'd0;
    bus_if.iSOURCE2_VAL = 8'd0;
    tick();
    tick();

    // Reset state
    check("rst_ready", bus_if.oREADY, 1'b1);
    check("rst_busy", bus_if.oBUSY, 1'b0);
    check_wb("rst", 1'b0, 2'd0, 8'd0);
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
    check("rst_zero", bus_if.oZERO, 1'b0);
    check("rst_carry", bus_if.oCARRY, 1'b0);
`endif
    iRST = 1'b0;
    tick();

    // ADD 200+100 wraps to 44
    issue(3'd1, 2'd1, 8'd200, 8'd100);
    tick();
    check_wb("add", 1'b1, 2'd1, 8'd44);
    bus_if.iVALID = 1'b0;
    tick();
    check_wb("add_hold", 1'b0, 2'd1, 8'd44);

    // Back-to-back SUB, XOR, MOV
    issue(3'd2, 2'd2, 8'd3, 8'd5);
    tick();
    check_wb("sub", 1'b1, 2'd2, 8'd254);
    check("sub_ready", bus_if.oREADY, 1'b1);
    issue(3'd5, 2'd3, 8'hF0, 8'hFF);
    tick();
    check_wb("xor", 1'b1, 2'd3, 8'h0F);
    check("xor_ready", bus_if.oREADY, 1'b1);
    issue(3'd0, 2'd0, 8'd99, 8'd7);
    tick();
    check_wb("mov", 1'b1, 2'd0, 8'd7);
    bus_if.iVALID = 1'b0;
    tick();
    check("mov_after_valid", bus_if.oWB_VALID, 1'b0);

    // MUL 13*11 with iVALID held high and a different op presented meanwhile
    issue(3'd6, 2'd2, 8'd13, 8'd11);
    tick();
    issue(3'd1, 2'd1, 8'd1, 8'd2);
    for (int i = 0; i < 8; i++) begin
      check("mul_ready_low", bus_if.oREADY, 1'b0);
      check("mul_busy", bus_if.oBUSY, 1'b1);
      check("mul_no_wb", bus_if.oWB_VALID, 1'b0);
      if (i < 7) tick();
    end
    tick();
    check_wb("mul", 1'b1, 2'd2, 8'd143);
    check("mul_done_ready", bus_if.oREADY, 1'b1);
    check("mul_done_busy", bus_if.oBUSY, 1'b0);
    // ADD presented in the writeback cycle is accepted at the next edge
    tick();
    check_wb("add_after_mul", 1'b1, 2'd1, 8'd3);
    bus_if.iVALID = 1'b0;
    tick();
    check("add_after_mul_end", bus_if.oWB_VALID, 1'b0);

    // MUL 20*20 = 400 -> 144
    issue(3'd6, 2'd3, 8'd20, 8'd20);
    tick();
    bus_if.iVALID = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check_wb("mul20", 1'b1, 2'd3, 8'd144);
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
    check("mul20_carry", bus_if.oCARRY, 1'b1);
    check("mul20_zero", bus_if.oZERO, 1'b0);
`endif
    issue(3'd1, 2'd0, 8'd128, 8'd128);
    tick();
    check_wb("add128", 1'b1, 2'd0, 8'd0);
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
    check("add128_zero", bus_if.oZERO, 1'b1);
    check("add128_carry", bus_if.oCARRY, 1'b1);
`endif
    bus_if.iVALID = 1'b0;
    tick();

    // Reset during MUL 3*3 aborts with no writeback
    issue(3'd6, 2'd1, 8'd3, 8'd3);
    tick();
    bus_if.iVALID = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    iRST = 1'b1;
    #1;
    check("abort_ready", bus_if.oREADY, 1'b1);
    check("abort_busy", bus_if.oBUSY, 1'b0);
    check_wb("abort", 1'b0, 2'd0, 8'd0);
    tick();
    iRST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus_if.oWB_VALID === 1'b1) pulses++;
    end
    check("abort_no_pulse", pulses, 0);

    // ADD then NOP: NOP leaves outputs untouched
    issue(3'd1, 2'd1, 8'd1, 8'd1);
    tick();
    check_wb("add11", 1'b1, 2'd1, 8'd2);
    issue(3'd7, 2'd3, 8'd9, 8'd9);
    tick();
    check_wb("nop", 1'b0, 2'd1, 8'd2);
`ifdef EXECUTE_WRITEBACK_FLAGS_EN
    check("nop_zero", bus_if.oZERO, 1'b0);
    check("nop_carry", bus_if.oCARRY, 1'b0);
`endif
    bus_if.iVALID = 1'b0;
    tick();
    check_wb("nop_hold", 1'b0, 2'd1, 8'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_writeback.md
Name: execute_writeback

Overview:
- Execute/writeback stage on the far side of the register-allocate stage.
- Consumes the latched source operands (src1, src2) and the destination register index, then computes the result.
- Drives the writeback bus (register index plus value, qualified by a valid strobe) back into the register file.
- Simple ALU ops are single-cycle; MUL is an iterative shift-add multiply under a small FSM with issue backpressure.

Parameters:
- DATA_W, 8, operand/result width in bits.
- REG_IDX_W, 2, destination register index width (4 registers).

Ports:
- iCLK  in  1  clock; all state updates on posedge.
- iRST  in  1  reset, asynchronous, active-high.
- iVALID  in  1  issue request; qualifies all iOP/iDST/iSRC inputs.
- oREADY  out  1  stage can accept an issue this cycle.
- iOP  in  3  opcode: 0 MOV, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MUL, 7 NOP.
- iDST_IDX  in  REG_IDX_W  destination register index.
- iSOURCE1_VAL  in  DATA_W  operand 1.
- iSOURCE2_VAL  in  DATA_W  operand 2 (register or immediate, already muxed upstream).
- oWB_VALID  out  1  one-cycle writeback strobe.
- oNEXT_REG_IDX  out  REG_IDX_W  writeback register index.
- oNEXT_REG_VAL  out  DATA_W  writeback value.
- oBUSY  out  1  multiply in progress.

Behaviour:
- Reset (async, asserted iRST) values:
  - FSM in IDLE; oREADY=1; oWB_VALID=0; oNEXT_REG_IDX=0; oNEXT_REG_VAL=0; oBUSY=0.
  - Multiply accumulator and counter cleared.
- Issue handshake:
  - An issue is accepted on a posedge where iVALID && oREADY; this edge is called E0.
  - oREADY = (state==IDLE), decoded combinationally from registered state.
  - Inputs are ignored when not accepted; upstream must hold them until accepted.
- FSM states: IDLE, MUL.
  - IDLE, accept op 0-5: result registered at E0; oWB_VALID=1 during the cycle after E0; stay in IDLE (back-to-back issue, one per cycle).
  - IDLE, accept op 7 (NOP): no writeback; oWB_VALID=0; index and value outputs hold.
  - IDLE, accept op 6 (MUL): latch operands and iDST_IDX at E0, clear accumulator and counter, go to MUL; oBUSY=1, oREADY=0.
  - MUL: one shift-add iteration per edge E1..E_DATA_W.
    - If multiplier bit[cnt] is set, acc += multiplicand << cnt.
    - At E_DATA_W, load the writeback outputs, pulse oWB_VALID for one cycle, return to IDLE (oREADY=1 in that same cycle).
  - MUL writeback is therefore visible exactly DATA_W cycles later than an ALU op issued at the same edge.
- Arithmetic and width rules:
  - All results are truncated to DATA_W bits (mod 2^DATA_W).
  - SUB = src1 - src2, two's complement wrap.
  - MUL result = low DATA_W bits of the full product.
  - MOV writes src2.
- Writeback outputs:
  - oWB_VALID is high for exactly one cycle per non-NOP op.
  - oNEXT_REG_IDX and oNEXT_REG_VAL hold their last values while oWB_VALID=0.
- Boundary conditions:
  - Reset mid-MUL: immediate abort to IDLE, no writeback pulse, partial product discarded.
  - iVALID held high during MUL: no acceptance until oREADY returns.
  - An op presented in the writeback cycle of a MUL is accepted at that edge.
  - An opcode change while not accepted has no effect.

Optional Feature:
- Macro: EXECUTE_WRITEBACK_FLAGS_EN.
- When defined, adds outputs oZERO (1 bit) and oCARRY (1 bit), registered alongside oNEXT_REG_VAL and updated only on writeback:
  - oZERO = (truncated result == 0).
  - oCARRY, ADD: carry out of bit DATA_W-1.
  - oCARRY, SUB: borrow (src1 < src2, unsigned).
  - oCARRY, MUL: 1 if any product bit at position >= DATA_W is set.
  - oCARRY, MOV/AND/OR/XOR: 0.
  - Both flags reset to 0; they hold on NOP.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then ADD dst=1, 200+100 -> next cycle oWB_VALID=1, IDX=1, VAL=44; following cycle oWB_VALID=0, outputs hold.
- Back-to-back SUB dst=2 3-5, XOR dst=3 0xF0^0xFF, MOV dst=0 src2=7 on consecutive edges -> three consecutive pulses: 254/IDX2, 15/IDX3, 7/IDX0; oREADY stays 1.
- MUL dst=2 13*11 (DATA_W=8) -> oREADY=0 and oBUSY=1 for 8 cycles; pulse with VAL=143, IDX=2 exactly 8 cycles after an ALU op would appear; iVALID held high is not accepted meanwhile.
- MUL 20*20 -> VAL=144 (400 mod 256); with EXECUTE_WRITEBACK_FLAGS_EN, oCARRY=1 and oZERO=0. ADD 128+128 -> VAL=0, oZERO=1, oCARRY=1.
- Assert iRST at iteration 4 of MUL 3*3 -> oREADY=1, oBUSY=0, oWB_VALID=0, outputs 0; no pulse ever appears for the aborted op.
- NOP dst=3 issued after ADD dst=1 1+1 -> no pulse for the NOP; IDX=1 and VAL=2 hold.
